multicycle_control: RTL and testbench

- Main control FSM for the multicycle MIPS datapath.
- Sequences instruction fetch, decode, execute, memory access and writeback.
- Drives the 2-bit aluop consumed by Alu_control (00 add, 01 subtract, 10 decode funct), plus all mux, enable and memory strobes.
- Stalls on a memory-ready handshake and reports retired and illegal instructions.

---
 rtl/multicycle_control.sv | 159 +++++++++++++++
 tb/tb_multicycle_control.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM; Moore decode of state, irwrite/pcwrite gated by mem_ready in FETCH.
// Latency 3-5 cycles per instruction; stalls in FETCH/MEMREAD/MEMWRITE while mem_ready is low.
module multicycle_control #(
    parameter int RETIRE_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              opcode,
    input  logic                    mem_ready,
    output logic                    pcwrite,
    output logic                    pcwritecond,
    output logic                    iord,
    output logic                    memread,
    output logic                    memwrite,
    output logic                    memtoreg,
    output logic                    irwrite,
    output logic                    regdst,
    output logic                    regwrite,
    output logic                    alusrca,
    output logic [1:0]              alusrcb,
    output logic [1:0]              aluop,
    output logic [1:0]              pcsource,
    output logic                    illegal_op,
    output logic                    instr_retired,
    output logic [RETIRE_CNT_W-1:0] retired_count,
    output logic [3:0]              state
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADDR  = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECUTE  = 4'd6;
    localparam logic [3:0] RTYPE_WB = 4'd7;
    localparam logic [3:0] BRANCH   = 4'd8;
    localparam logic [3:0] JUMP     = 4'd9;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0] next_state;
    logic       illegal_nxt;
    logic       retire_nxt;

    always_comb begin
        next_state  = FETCH;
        illegal_nxt = 1'b0;
        retire_nxt  = 1'b0;
        case (state)
            FETCH:    next_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = MEMADDR;
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
                    default: begin
                        next_state  = FETCH;
                        illegal_nxt = 1'b1;
                    end
                endcase
            end
            // Only lw/sw reach MEMADDR, so anything that is not sw is treated as lw.
            MEMADDR:  next_state = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  next_state = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    retire_nxt = 1'b1;
            MEMWRITE: begin
                next_state = mem_ready ? FETCH : MEMWRITE;
                retire_nxt = mem_ready;
            end
            EXECUTE:  next_state = RTYPE_WB;
            RTYPE_WB: retire_nxt = 1'b1;
            BRANCH:   retire_nxt = 1'b1;
            JUMP:     retire_nxt = 1'b1;
            default:  next_state = FETCH;
        endcase
    end

    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = 1'b0;
        irwrite     = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        aluop       = 2'b00;
        pcsource    = 2'b00;
        case (state)
            FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            DECODE:   alusrcb = 2'b11;
            MEMADDR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMREAD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            MEMWRITE: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            RTYPE_WB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            BRANCH: begin
                alusrca     = 1'b1;
                aluop       = 2'b01;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
            end
            JUMP: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= FETCH;
            illegal_op    <= 1'b0;
            instr_retired <= 1'b0;
            retired_count <= '0;
        end else begin
            state         <= next_state;
            illegal_op    <= illegal_nxt;
            instr_retired <= retire_nxt;
            if (retire_nxt)
                retired_count <= retired_count + RETIRE_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control; a second instance with a 2-bit counter covers wrap-around.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;

    logic        pcwrite, pcwritecond, iord, memread, memwrite, memtoreg;
    logic        irwrite, regdst, regwrite, alusrca, illegal_op, instr_retired;
    logic [1:0]  alusrcb, aluop, pcsource;
    logic [15:0] retired_count;
    logic [3:0]  state;

    logic        pcwrite2, pcwritecond2, iord2, memread2, memwrite2, memtoreg2;
    logic        irwrite2, regdst2, regwrite2, alusrca2, illegal_op2, instr_retired2;
    logic [1:0]  alusrcb2, aluop2, pcsource2;
    logic [1:0]  retired_count2;
    logic [3:0]  state2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_control #(.RETIRE_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
        .memwrite(memwrite), .memtoreg(memtoreg), .irwrite(irwrite), .regdst(regdst),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
        .pcsource(pcsource), .illegal_op(illegal_op), .instr_retired(instr_retired),
        .retired_count(retired_count), .state(state)
    );

    multicycle_control #(.RETIRE_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pcwrite(pcwrite2), .pcwritecond(pcwritecond2), .iord(iord2), .memread(memread2),
        .memwrite(memwrite2), .memtoreg(memtoreg2), .irwrite(irwrite2), .regdst(regdst2),
        .regwrite(regwrite2), .alusrca(alusrca2), .alusrcb(alusrcb2), .aluop(aluop2),
        .pcsource(pcsource2), .illegal_op(illegal_op2), .instr_retired(instr_retired2),
        .retired_count(retired_count2), .state(state2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs set here are settled with #1 before checks.
    task automatic go();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 6'b000000;
        mem_ready = 1'b0;
        go();
        go();
        #1;
        check("reset_state", state, 0);
        check("reset_memread", memread, 1);
        check("reset_alusrcb", alusrcb, 2'b01);
        check("reset_irwrite", irwrite, 0);
        check("reset_pcwrite", pcwrite, 0);
        check("reset_count", retired_count, 0);
        check("reset_illegal", illegal_op, 0);
        check("reset_retired", instr_retired, 0);

        // R-type: 0,1,6,7,0
        rst = 1'b0; opcode = 6'b000000; mem_ready = 1'b1; #1;
        check("r_fetch_state", state, 0);
        check("r_fetch_irwrite", irwrite, 1);
        check("r_fetch_pcwrite", pcwrite, 1);
        go();
        check("r_dec_state", state, 1);
        check("r_dec_alusrcb", alusrcb, 2'b11);
        check("r_dec_aluop", aluop, 2'b00);
        go();
        check("r_exe_state", state, 6);
        check("r_exe_aluop", aluop, 2'b10);
        check("r_exe_alusrca", alusrca, 1);
        check("r_exe_alusrcb", alusrcb, 2'b00);
        go();
        check("r_wb_state", state, 7);
        check("r_wb_regwrite", regwrite, 1);
        check("r_wb_regdst", regdst, 1);
        check("r_wb_memtoreg", memtoreg, 0);
        check("r_wb_aluop", aluop, 2'b00);
        check("r_wb_retired", instr_retired, 0);
        go();
        check("r_done_state", state, 0);
        check("r_done_retired", instr_retired, 1);
        check("r_done_count", retired_count, 1);

        // lw with two stall cycles in MEMREAD: 0,1,2,3,3,3,4,0
        opcode = 6'b100011; #1;
        go();
        check("lw_dec_state", state, 1);
        check("lw_dec_retired", instr_retired, 0);
        go();
        check("lw_addr_state", state, 2);
        check("lw_addr_alusrca", alusrca, 1);
        check("lw_addr_alusrcb", alusrcb, 2'b10);
        go();
        mem_ready = 1'b0; #1;
        check("lw_rd0_state", state, 3);
        check("lw_rd0_memread", memread, 1);
        check("lw_rd0_iord", iord, 1);
        go();
        check("lw_rd1_state", state, 3);
        check("lw_rd1_memread", memread, 1);
        go();
        mem_ready = 1'b1; #1;
        check("lw_rd2_state", state, 3);
        check("lw_rd2_iord", iord, 1);
        go();
        check("lw_wb_state", state, 4);
        check("lw_wb_regwrite", regwrite, 1);
        check("lw_wb_memtoreg", memtoreg, 1);
        check("lw_wb_regdst", regdst, 0);
        go();
        check("lw_done_state", state, 0);
        check("lw_done_retired", instr_retired, 1);
        check("lw_done_count", retired_count, 2);

        // sw: 0,1,2,5,0
        opcode = 6'b101011; #1;
        go();
        go();
        check("sw_addr_state", state, 2);
        go();
        check("sw_wr_state", state, 5);
        check("sw_wr_memwrite", memwrite, 1);
        check("sw_wr_iord", iord, 1);
        check("sw_wr_memread", memread, 0);
        go();
        check("sw_done_state", state, 0);
        check("sw_done_count", retired_count, 3);

        // beq: 0,1,8,0
        opcode = 6'b000100; #1;
        go();
        go();
        check("beq_state", state, 8);
        check("beq_aluop", aluop, 2'b01);
        check("beq_pcwritecond", pcwritecond, 1);
        check("beq_pcsource", pcsource, 2'b01);
        check("beq_alusrca", alusrca, 1);
        check("beq_pcwrite", pcwrite, 0);
        go();
        check("beq_done_state", state, 0);
        check("beq_done_count", retired_count, 4);

        // j: 0,1,9,0
        opcode = 6'b000010; #1;
        go();
        go();
        check("j_state", state, 9);
        check("j_pcwrite", pcwrite, 1);
        check("j_pcsource", pcsource, 2'b10);
        check("j_pcwritecond", pcwritecond, 0);
        go();
        check("j_done_state", state, 0);
        check("j_done_count", retired_count, 5);
        check("j_done_count2", retired_count2, 1);

        // FETCH stall for three cycles, then R-type
        opcode = 6'b000000; mem_ready = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            check("stall_state", state, 0);
            check("stall_irwrite", irwrite, 0);
            check("stall_pcwrite", pcwrite, 0);
            go();
        end
        mem_ready = 1'b1; #1;
        check("stall_end_state", state, 0);
        check("stall_end_irwrite", irwrite, 1);
        check("stall_end_pcwrite", pcwrite, 1);
        go();
        check("stall_dec_state", state, 1);
        go();
        go();
        go();
        check("stall_r_done_state", state, 0);
        check("stall_r_done_count", retired_count, 6);

        // Illegal opcode: 0,1,0 with a single illegal_op pulse, no retire
        opcode = 6'b111111; #1;
        go();
        check("ill_dec_state", state, 1);
        check("ill_dec_flag", illegal_op, 0);
        go();
        check("ill_back_state", state, 0);
        check("ill_pulse", illegal_op, 1);
        check("ill_not_retired", instr_retired, 0);
        check("ill_count", retired_count, 6);
        opcode = 6'b000000; #1;
        go();
        check("ill_pulse_end", illegal_op, 0);
        check("ill_count_after", retired_count, 6);
        go();
        go();
        go();
        check("r7_count", retired_count, 7);
        check("r7_count2", retired_count2, 3);

        // Reset while stalled in MEMREAD
        opcode = 6'b100011; #1;
        go();
        go();
        go();
        mem_ready = 1'b0; #1;
        check("rst_mid_pre_state", state, 3);
        rst = 1'b1;
        go();
        check("rst_mid_state", state, 0);
        check("rst_mid_count", retired_count, 0);
        check("rst_mid_count2", retired_count2, 0);
        check("rst_mid_memread", memread, 1);
        check("rst_mid_alusrcb", alusrcb, 2'b01);
        check("rst_mid_retired", instr_retired, 0);

        // Four R-types wrap the 2-bit counter back to zero
        rst = 1'b0; opcode = 6'b000000; mem_ready = 1'b1; #1;
        for (int k = 1; k <= 4; k++) begin
            go();
            go();
            go();
            go();
            check("wrap_state", state, 0);
            check("wrap_count", retired_count, k);
            check("wrap_count2", retired_count2, k % 4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
